// File: rtl/axil_pkg.sv
// Shared types for the AXI-Lite write command queue: response codes, FSM states
// and the packed command record stored in the FIFO.
package axil_pkg;

  // Widest command the queue stores; the top casts its ADDR_W/DATA_W ports onto these.
  localparam int CMD_ADDR_W = 32;
  localparam int CMD_DATA_W = 32;
  localparam int CMD_STRB_W = CMD_DATA_W / 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } wr_state_e;

  typedef struct packed {
    logic [CMD_ADDR_W-1:0] addr;
    logic [CMD_DATA_W-1:0] data;
    logic [CMD_STRB_W-1:0] strb;
  } wr_cmd_t;

  // Anything other than a plain OKAY counts against the error counter.
  function automatic logic resp_is_err(input logic [1:0] resp);
    logic err;
    unique case (resp)
      RESP_OKAY:                             err = 1'b0;
      RESP_EXOKAY, RESP_SLVERR, RESP_DECERR: err = 1'b1;
      default:                               err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/axil_cmd_fifo.sv
// Synchronous FIFO of wr_cmd_t with a combinational head and an occupancy count
// from which full/empty are derived.
module axil_cmd_fifo
  import axil_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   m_axi_aclk,
  input  logic                   m_axi_areset,
  input  logic                   push,
  input  wr_cmd_t                push_data,
  input  logic                   pop,
  output wr_cmd_t                head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int PTR_W = $clog2(DEPTH);

  wr_cmd_t          mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  // A full FIFO refuses a push even when a pop lands on the same edge.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge m_axi_aclk) begin
    if (m_axi_areset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge m_axi_aclk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/axil_wr_cmd_queue.sv
// Write command queue feeding an AXI-Lite write master one command at a time,
// tapping its B channel for status. Define AXIL_WR_TIMEOUT_EN for the response watchdog.
module axil_wr_cmd_queue
  import axil_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int ERR_W       = 8,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                   m_axi_aclk,
  input  logic                   m_axi_areset,
  input  logic                   s_cmd_valid,
  output logic                   s_cmd_ready,
  input  logic [ADDR_W-1:0]      s_cmd_addr,
  input  logic [DATA_W-1:0]      s_cmd_data,
  input  logic [DATA_W/8-1:0]    s_cmd_strb,
  output logic                   o_wr,
  output logic [ADDR_W-1:0]      o_addr,
  output logic [DATA_W-1:0]      o_din,
  output logic [DATA_W/8-1:0]    o_strb,
  input  logic                   i_bvalid,
  input  logic                   i_bready,
  input  logic [1:0]             i_bresp,
  output logic                   o_busy,
  output logic [$clog2(DEPTH):0] o_count,
  output logic [ERR_W-1:0]       o_err_cnt,
  output logic [1:0]             o_last_resp,
  output logic                   o_timeout
);

  localparam int STRB_W = DATA_W / 8;

  // Handshakes: a command transfers on any edge with s_cmd_valid && s_cmd_ready
  // (ready is simply !full); a response completes on any edge with
  // i_bvalid && i_bready, but only counts while the FSM is in WAIT.
  wr_state_e state;
  wr_cmd_t   push_cmd;
  wr_cmd_t   head_cmd;
  logic      fifo_full;
  logic      fifo_empty;
  logic      pop;
  logic      b_hs;

  always_comb begin
    push_cmd      = '0;
    push_cmd.addr = CMD_ADDR_W'(s_cmd_addr);
    push_cmd.data = CMD_DATA_W'(s_cmd_data);
    push_cmd.strb = CMD_STRB_W'(s_cmd_strb);
  end

  assign s_cmd_ready = !fifo_full;
  assign pop         = (state == IDLE) && !fifo_empty;
  assign b_hs        = i_bvalid && i_bready;

  axil_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .m_axi_aclk   (m_axi_aclk),
    .m_axi_areset (m_axi_areset),
    .push         (s_cmd_valid && s_cmd_ready),
    .push_data    (push_cmd),
    .pop          (pop),
    .head         (head_cmd),
    .count        (o_count),
    .full         (fifo_full),
    .empty        (fifo_empty)
  );

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

`ifdef AXIL_WR_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0] wd_cnt;
`else
  localparam int unused_timeout_cyc = TIMEOUT_CYC;
  assign o_timeout = 1'b0;
`endif

  always_ff @(posedge m_axi_aclk) begin
    if (m_axi_areset) begin
      state       <= IDLE;
      o_wr        <= 1'b0;
      o_busy      <= 1'b0;
      o_addr      <= '0;
      o_din       <= '0;
      o_strb      <= '0;
      o_err_cnt   <= '0;
      o_last_resp <= RESP_OKAY;
`ifdef AXIL_WR_TIMEOUT_EN
      wd_cnt      <= '0;
      o_timeout   <= 1'b0;
`endif
    end else begin
      o_wr <= 1'b0;
`ifdef AXIL_WR_TIMEOUT_EN
      o_timeout <= 1'b0;
`endif
      unique case (state)
        IDLE: begin
          if (pop) begin
            o_addr <= ADDR_W'(head_cmd.addr);
            o_din  <= DATA_W'(head_cmd.data);
            o_strb <= STRB_W'(head_cmd.strb);
            o_wr   <= 1'b1;
            o_busy <= 1'b1;
            state  <= ISSUE;
          end
        end
        ISSUE: begin
`ifdef AXIL_WR_TIMEOUT_EN
          wd_cnt <= '0;
`endif
          state <= WAIT;
        end
        WAIT: begin
          if (b_hs) begin
            o_last_resp <= i_bresp;
            if (resp_is_err(i_bresp)) o_err_cnt <= sat_inc(o_err_cnt);
            o_busy <= 1'b0;
            state  <= IDLE;
          end
`ifdef AXIL_WR_TIMEOUT_EN
          // Last WAIT cycle of the TIMEOUT_CYC budget without a response.
          else if (wd_cnt == WD_W'(TIMEOUT_CYC - 1)) begin
            o_timeout   <= 1'b1;
            o_last_resp <= RESP_SLVERR;
            o_err_cnt   <= sat_inc(o_err_cnt);
            o_busy      <= 1'b0;
            state       <= IDLE;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
`endif
        end
        default: begin
          o_busy <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axil_wr_cmd_queue.sv
// Directed bench for axil_wr_cmd_queue: single write, fill/order, error status,
// simultaneous push/pop, mid-operation reset and watchdog behaviour.
module tb_axil_wr_cmd_queue;

  localparam int DEPTH       = 8;
  localparam int ADDR_W      = 32;
  localparam int DATA_W      = 32;
  localparam int ERR_W       = 8;
  localparam int TIMEOUT_CYC = 16;

  logic                   m_axi_aclk = 1'b0;
  logic                   m_axi_areset = 1'b1;
  logic                   s_cmd_valid = 1'b0;
  logic                   s_cmd_ready;
  logic [ADDR_W-1:0]      s_cmd_addr = '0;
  logic [DATA_W-1:0]      s_cmd_data = '0;
  logic [DATA_W/8-1:0]    s_cmd_strb = '0;
  logic                   o_wr;
  logic [ADDR_W-1:0]      o_addr;
  logic [DATA_W-1:0]      o_din;
  logic [DATA_W/8-1:0]    o_strb;
  logic                   i_bvalid = 1'b0;
  logic                   i_bready = 1'b0;
  logic [1:0]             i_bresp = 2'b00;
  logic                   o_busy;
  logic [$clog2(DEPTH):0] o_count;
  logic [ERR_W-1:0]       o_err_cnt;
  logic [1:0]             o_last_resp;
  logic                   o_timeout;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;
  int last_wr      = 0;
  logic timeout_seen;
  logic [ADDR_W-1:0] exp_q[$];

  axil_wr_cmd_queue #(
    .DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .ERR_W(ERR_W), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .m_axi_aclk   (m_axi_aclk),
    .m_axi_areset (m_axi_areset),
    .s_cmd_valid  (s_cmd_valid),
    .s_cmd_ready  (s_cmd_ready),
    .s_cmd_addr   (s_cmd_addr),
    .s_cmd_data   (s_cmd_data),
    .s_cmd_strb   (s_cmd_strb),
    .o_wr         (o_wr),
    .o_addr       (o_addr),
    .o_din        (o_din),
    .o_strb       (o_strb),
    .i_bvalid     (i_bvalid),
    .i_bready     (i_bready),
    .i_bresp      (i_bresp),
    .o_busy       (o_busy),
    .o_count      (o_count),
    .o_err_cnt    (o_err_cnt),
    .o_last_resp  (o_last_resp),
    .o_timeout    (o_timeout)
  );

  // Clock / reset-independent cycle counter
  always #5 m_axi_aclk = ~m_axi_aclk;
  always @(posedge m_axi_aclk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL global_timeout: observed no finish, expected finish before 200us");
    $fatal(1, "bench time limit expired");
  end

  // Driver tasks
  task automatic tick();
    @(posedge m_axi_aclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_cmd(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                          input logic [DATA_W/8-1:0] s);
    s_cmd_valid = 1'b1;
    s_cmd_addr  = a;
    s_cmd_data  = d;
    s_cmd_strb  = s;
    tick();
    s_cmd_valid = 1'b0;
  endtask

  task automatic b_respond(input logic [1:0] resp);
    i_bvalid = 1'b1;
    i_bready = 1'b1;
    i_bresp  = resp;
    tick();
    i_bvalid = 1'b0;
    i_bready = 1'b0;
    i_bresp  = 2'b00;
  endtask

  task automatic wait_wr(input string tag);
    int n = 0;
    while (!o_wr && n < 50) begin
      tick();
      n++;
    end
    check(tag, 64'(o_wr), 64'd1);
  endtask

  initial begin
    // Reset
    m_axi_areset = 1'b1;
    repeat (3) tick();
    m_axi_areset = 1'b0;
    tick();
    check("rst_wr", 64'(o_wr), 0);
    check("rst_busy", 64'(o_busy), 0);
    check("rst_count", 64'(o_count), 0);
    check("rst_err", 64'(o_err_cnt), 0);
    check("rst_last", 64'(o_last_resp), 0);
    check("rst_timeout", 64'(o_timeout), 0);
    check("rst_ready", 64'(s_cmd_ready), 1);
    check("rst_addr", 64'(o_addr), 0);

    // Single write: o_wr high in the cycle after edge N+1
    push_cmd(32'h3, 32'hDEADBEEF, 4'hF);
    check("t1_count_push", 64'(o_count), 1);
    check("t1_wr_early", 64'(o_wr), 0);
    tick();
    check("t1_wr", 64'(o_wr), 1);
    check("t1_addr", 64'(o_addr), 64'h3);
    check("t1_din", 64'(o_din), 64'hDEADBEEF);
    check("t1_strb", 64'(o_strb), 64'hF);
    check("t1_busy_issue", 64'(o_busy), 1);
    check("t1_count_pop", 64'(o_count), 0);
    tick();
    check("t1_wr_pulse", 64'(o_wr), 0);
    check("t1_addr_hold", 64'(o_addr), 64'h3);
    tick();
    check("t1_busy_wait", 64'(o_busy), 1);
    b_respond(2'b00);
    check("t1_busy_done", 64'(o_busy), 0);
    check("t1_last", 64'(o_last_resp), 0);
    check("t1_err", 64'(o_err_cnt), 0);

    // Error response then OKAY
    push_cmd(32'h20, 32'hA5A5A5A5, 4'h3);
    tick();
    check("err_wr", 64'(o_wr), 1);
    check("err_addr", 64'(o_addr), 64'h20);
    tick();
    b_respond(2'b11);
    check("err_last", 64'(o_last_resp), 64'h3);
    check("err_cnt", 64'(o_err_cnt), 1);
    push_cmd(32'h24, 32'h12345678, 4'hC);
    tick();
    tick();
    b_respond(2'b00);
    check("ok_last", 64'(o_last_resp), 0);
    check("ok_err_hold", 64'(o_err_cnt), 1);

    // Fill and ordering: c0 outstanding, then 9 more pushed back-to-back
    push_cmd(32'h100, 32'h0, 4'hF);
    tick();
    check("f_wr0", 64'(o_wr), 1);
    check("f_addr0", 64'(o_addr), 64'h100);
    tick();
    s_cmd_valid = 1'b1;
    s_cmd_strb  = 4'hF;
    for (int i = 1; i <= 8; i++) begin
      s_cmd_addr = 32'h100 + 32'(i * 4);
      s_cmd_data = 32'(i);
      exp_q.push_back(s_cmd_addr);
      tick();
    end
    check("f_full_count", 64'(o_count), 8);
    check("f_full_ready", 64'(s_cmd_ready), 0);
    s_cmd_addr = 32'h124;
    s_cmd_data = 32'd9;
    exp_q.push_back(s_cmd_addr);
    repeat (3) tick();
    check("f_blocked_count", 64'(o_count), 8);
    check("f_blocked_wr", 64'(o_wr), 0);
    b_respond(2'b00);
    check("f_idle_count", 64'(o_count), 8);
    check("f_idle_busy", 64'(o_busy), 0);
    tick();
    check("full_pop_push_count", 64'(o_count), 7);
    check("f_wr1", 64'(o_wr), 1);
    check("f_order", 64'(o_addr), 64'(exp_q.pop_front()));
    last_wr = cyc;
    tick();
    s_cmd_valid = 1'b0;
    check("f_ninth_accepted", 64'(o_count), 8);
    for (int k = 0; k < 8; k++) begin
      b_respond(2'b00);
      wait_wr("f_wr_seen");
      check("f_order", 64'(o_addr), 64'(exp_q.pop_front()));
      check("f_spacing", 64'((cyc - last_wr) >= 3), 1);
      last_wr = cyc;
      tick();
    end
    check("f_drained", 64'(o_count), 0);
    check("f_q_empty", 64'(exp_q.size()), 0);
    b_respond(2'b00);
    check("f_final_busy", 64'(o_busy), 0);

    // Simultaneous push/pop at count=1, then reset in WAIT with 3 queued
    push_cmd(32'h200, 32'h1, 4'h1);
    push_cmd(32'h204, 32'h2, 4'h2);
    check("sim_push_pop_count", 64'(o_count), 1);
    check("sim_wr", 64'(o_wr), 1);
    check("sim_addr", 64'(o_addr), 64'h200);
    push_cmd(32'h208, 32'h3, 4'h4);
    push_cmd(32'h20C, 32'h4, 4'h8);
    check("mr_count", 64'(o_count), 3);
    check("mr_busy", 64'(o_busy), 1);
    check("mr_err_before", 64'(o_err_cnt), 1);
    m_axi_areset = 1'b1;
    tick();
    m_axi_areset = 1'b0;
    check("mr_count_rst", 64'(o_count), 0);
    check("mr_busy_rst", 64'(o_busy), 0);
    check("mr_wr_rst", 64'(o_wr), 0);
    check("mr_err_rst", 64'(o_err_cnt), 0);
    check("mr_ready_rst", 64'(s_cmd_ready), 1);
    push_cmd(32'h300, 32'hCAFEF00D, 4'hF);
    tick();
    check("mr_new_wr", 64'(o_wr), 1);
    check("mr_new_addr", 64'(o_addr), 64'h300);
    check("mr_new_din", 64'(o_din), 64'hCAFEF00D);
    tick();
    b_respond(2'b00);
    check("mr_new_done", 64'(o_busy), 0);

`ifdef AXIL_WR_TIMEOUT_EN
    // Watchdog: 16 WAIT cycles without a response
    push_cmd(32'h400, 32'h0, 4'hF);
    push_cmd(32'h404, 32'h1, 4'hF);
    tick();
    repeat (15) tick();
    check("wd_not_yet", 64'(o_timeout), 0);
    check("wd_busy_wait", 64'(o_busy), 1);
    tick();
    check("wd_pulse", 64'(o_timeout), 1);
    check("wd_busy", 64'(o_busy), 0);
    check("wd_last", 64'(o_last_resp), 64'h2);
    check("wd_err", 64'(o_err_cnt), 1);
    tick();
    check("wd_pulse_end", 64'(o_timeout), 0);
    check("wd_next_wr", 64'(o_wr), 1);
    check("wd_next_addr", 64'(o_addr), 64'h404);
    b_respond(2'b11);
    check("wd_late_last", 64'(o_last_resp), 64'h2);
    check("wd_late_err", 64'(o_err_cnt), 1);
    check("wd_late_busy", 64'(o_busy), 1);
    b_respond(2'b00);
    check("wd_ok_last", 64'(o_last_resp), 0);
    check("wd_ok_err", 64'(o_err_cnt), 1);
    check("wd_ok_busy", 64'(o_busy), 0);
`else
    // No watchdog: WAIT holds indefinitely
    push_cmd(32'h400, 32'h0, 4'hF);
    tick();
    tick();
    timeout_seen = 1'b0;
    repeat (1000) begin
      tick();
      if (o_timeout) timeout_seen = 1'b1;
    end
    check("nowd_busy", 64'(o_busy), 1);
    check("nowd_timeout", 64'(timeout_seen), 0);
    check("nowd_wr", 64'(o_wr), 0);
    check("nowd_last", 64'(o_last_resp), 0);
    b_respond(2'b00);
    check("nowd_done", 64'(o_busy), 0);
`endif

    // Final report
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
